// File: rtl/adc_autocfg_pkg.sv
// Shared state encoding and width helper for the ADC auto-configuration sequencer.
package adc_autocfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RST,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FINISH
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int widthOf(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_autocfg_timer.sv
// Loadable down-counter shared by the post-reset wait and the per-write timeout.
// o_expired is high whenever the count rests at zero.
module adc_autocfg_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/adc_autocfg_seq.sv
// Walks every enabled ADC through its register table via the serial config engine.
// Define ADC_AUTOCFG_TIMEOUT_EN to add per-write timeout, retry and error reporting.
module adc_autocfg_seq
  import adc_autocfg_pkg::*;
#(
  parameter int NUM_ADC   = 4,
  parameter int NUM_REGS  = 16,
  parameter int RST_WAIT  = 1023,
  parameter int TIMEOUT   = 4095,
  parameter int MAX_RETRY = 2,
  localparam int ADC_W    = widthOf(NUM_ADC),
  localparam int REG_W    = widthOf(NUM_REGS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_init,
  input  logic               i_adcRst,
  input  logic               i_restart,
  input  logic               i_cfgBusyExt,
  input  logic [NUM_ADC-1:0] i_adcMask,
  input  logic               i_cfgDone,
  output logic               o_cfgStart,
  output logic [ADC_W-1:0]   o_cfgAdcSel,
  output logic [REG_W-1:0]   o_cfgRegIdx,
  output logic               o_run,
  output logic               o_autoconfDone,
  output logic               o_autoconfErr,
  output logic [ADC_W-1:0]   o_errAdc,
  output logic [REG_W-1:0]   o_errReg
);

  localparam int TMR_MAX = (RST_WAIT > TIMEOUT) ? RST_WAIT : TIMEOUT;
  localparam int TMR_W   = widthOf(TMR_MAX);
  localparam logic [ADC_W-1:0] ADC_LAST = ADC_W'(NUM_ADC - 1);
  localparam logic [REG_W-1:0] REG_LAST = REG_W'(NUM_REGS - 1);
  localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RST_WAIT - 1);

  state_t             r_state, w_stateNext;
  logic               r_pending;
  logic [NUM_ADC-1:0] r_maskQ;
  logic [ADC_W-1:0]   r_adc, w_adcNext;
  logic [REG_W-1:0]   r_reg, w_regNext;
  logic               w_arm;
  logic               w_tmrLoad, w_tmrEn, w_tmrExpired;
  logic [TMR_W-1:0]   w_tmrLoadVal;

`ifdef ADC_AUTOCFG_TIMEOUT_EN
  localparam int RETRY_W = widthOf(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [TMR_W-1:0]   TO_LOAD   = TMR_W'(TIMEOUT - 1);

  logic [RETRY_W-1:0] r_retry, w_retryNext;
  logic               r_err, w_errNext;
  logic [ADC_W-1:0]   r_errAdc, w_errAdcNext;
  logic [REG_W-1:0]   r_errReg, w_errRegNext;
`endif

  assign w_arm = (r_state == ST_IDLE) & i_init & r_pending & ~i_cfgBusyExt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Abort on adc_rst takes precedence and leaves all indices untouched;
  // they are cleared again when the sequence rearms.
  always_comb begin
    w_stateNext = r_state;
    w_adcNext   = r_adc;
    w_regNext   = r_reg;
`ifdef ADC_AUTOCFG_TIMEOUT_EN
    w_retryNext  = r_retry;
    w_errNext    = r_err;
    w_errAdcNext = r_errAdc;
    w_errRegNext = r_errReg;
`endif
    if (i_adcRst && (r_state != ST_IDLE)) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arm) begin
            w_stateNext = ST_WAIT_RST;
            w_adcNext   = '0;
            w_regNext   = '0;
`ifdef ADC_AUTOCFG_TIMEOUT_EN
            w_retryNext  = '0;
            w_errNext    = 1'b0;
            w_errAdcNext = '0;
            w_errRegNext = '0;
`endif
          end
        end
        ST_WAIT_RST: begin
          if (w_tmrExpired) w_stateNext = ST_SELECT;
        end
        ST_SELECT: begin
          if (r_maskQ[r_adc]) w_stateNext = ST_ISSUE;
          else if (r_adc == ADC_LAST) w_stateNext = ST_FINISH;
          else w_adcNext = r_adc + 1'b1;
        end
        ST_ISSUE: w_stateNext = ST_WAIT;
        ST_WAIT: begin
          if (i_cfgDone) begin
            w_stateNext = ST_NEXT;
`ifdef ADC_AUTOCFG_TIMEOUT_EN
          end else if (w_tmrExpired) begin
            if (r_retry < RETRY_MAX) begin
              w_retryNext = r_retry + 1'b1;
              w_stateNext = ST_ISSUE;
            end else begin
              w_errNext   = 1'b1;
              w_retryNext = '0;
              w_regNext   = '0;
              if (!r_err) begin
                w_errAdcNext = r_adc;
                w_errRegNext = r_reg;
              end
              if (r_adc == ADC_LAST) begin
                w_stateNext = ST_FINISH;
              end else begin
                w_adcNext   = r_adc + 1'b1;
                w_stateNext = ST_SELECT;
              end
            end
`endif
          end
        end
        ST_NEXT: begin
`ifdef ADC_AUTOCFG_TIMEOUT_EN
          w_retryNext = '0;
`endif
          if (r_reg == REG_LAST) begin
            w_regNext = '0;
            if (r_adc == ADC_LAST) begin
              w_stateNext = ST_FINISH;
            end else begin
              w_adcNext   = r_adc + 1'b1;
              w_stateNext = ST_SELECT;
            end
          end else begin
            w_regNext   = r_reg + 1'b1;
            w_stateNext = ST_ISSUE;
          end
        end
        ST_FINISH: w_stateNext = ST_IDLE;
        default:   w_stateNext = ST_IDLE;
      endcase
    end
  end

  // Set requests win over the clear caused by arming in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= 1'b1;
      r_maskQ   <= '0;
      r_adc     <= '0;
      r_reg     <= '0;
    end else begin
      r_pending <= (r_pending & ~w_arm) | i_adcRst | i_restart;
      if (w_arm) r_maskQ <= i_adcMask;
      r_adc <= w_adcNext;
      r_reg <= w_regNext;
    end
  end

`ifdef ADC_AUTOCFG_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_retry  <= '0;
      r_err    <= 1'b0;
      r_errAdc <= '0;
      r_errReg <= '0;
    end else begin
      r_retry  <= w_retryNext;
      r_err    <= w_errNext;
      r_errAdc <= w_errAdcNext;
      r_errReg <= w_errRegNext;
    end
  end

  assign w_tmrLoad     = (r_state == ST_IDLE) | (r_state == ST_ISSUE);
  assign w_tmrLoadVal  = (r_state == ST_ISSUE) ? TO_LOAD : RST_LOAD;
  assign o_autoconfErr = r_err;
  assign o_errAdc      = r_errAdc;
  assign o_errReg      = r_errReg;
`else
  assign w_tmrLoad     = (r_state == ST_IDLE);
  assign w_tmrLoadVal  = RST_LOAD;
  assign o_autoconfErr = 1'b0;
  assign o_errAdc      = '0;
  assign o_errReg      = '0;
`endif

  assign w_tmrEn = (r_state == ST_WAIT_RST) | (r_state == ST_WAIT);

  adc_autocfg_timer #(.W(TMR_W)) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_tmrLoad),
    .i_loadVal (w_tmrLoadVal),
    .i_en      (w_tmrEn),
    .o_expired (w_tmrExpired)
  );

  assign o_cfgStart     = (r_state == ST_ISSUE);
  assign o_cfgAdcSel    = r_adc;
  assign o_cfgRegIdx    = r_reg;
  assign o_run          = r_pending | (r_state != ST_IDLE);
  assign o_autoconfDone = (r_state == ST_FINISH);

endmodule

// File: tb/tb_adc_autocfg_seq.sv
// Scoreboard bench for adc_autocfg_seq: expected starts/done pulses are queued by the
// stimulus and consumed by an independent monitor. Timeout test needs ADC_AUTOCFG_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_adc_autocfg_seq;

  localparam int NUM_ADC   = 2;
  localparam int NUM_REGS  = 3;
  localparam int RST_WAIT  = 4;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;

  typedef enum int {EV_START, EV_DONE} evKind_t;
  typedef struct {
    evKind_t kind;
    int      adc;
    int      regIdx;
  } scbItem_t;

  scbItem_t expQ[$];
  int nChecks = 0;
  int nErrors = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b1;
  logic       adcRst = 1'b0;
  logic       restart = 1'b0;
  logic       cfgBusyExt = 1'b0;
  logic [1:0] adcMask = 2'b11;
  logic       cfgDone;
  logic       cfgStart;
  logic [0:0] cfgAdcSel;
  logic [1:0] cfgRegIdx;
  logic       run;
  logic       autoconfDone;
  logic       autoconfErr;
  logic [0:0] errAdc;
  logic [1:0] errReg;
  bit         dropEn = 1'b0;

  adc_autocfg_seq #(
    .NUM_ADC(NUM_ADC), .NUM_REGS(NUM_REGS), .RST_WAIT(RST_WAIT),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_adcRst(adcRst),
    .i_restart(restart), .i_cfgBusyExt(cfgBusyExt), .i_adcMask(adcMask),
    .i_cfgDone(cfgDone), .o_cfgStart(cfgStart), .o_cfgAdcSel(cfgAdcSel),
    .o_cfgRegIdx(cfgRegIdx), .o_run(run), .o_autoconfDone(autoconfDone),
    .o_autoconfErr(autoconfErr), .o_errAdc(errAdc), .o_errReg(errReg)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input evKind_t kind, input int adc, input int regIdx);
    scbItem_t e;
    nChecks++;
    if (expQ.size() == 0) begin
      nErrors++;
      $display("[TB] FAIL unexpected event: got %s(%0d,%0d), expected nothing", kind.name(), adc, regIdx);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.adc != adc || e.regIdx != regIdx) begin
        nErrors++;
        $display("[TB] FAIL sequence: got %s(%0d,%0d), expected %s(%0d,%0d)",
                 kind.name(), adc, regIdx, e.kind.name(), e.adc, e.regIdx);
      end
    end
  endtask

  // Monitor: every start or done pulse the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfgStart) checkOutput(EV_START, int'(cfgAdcSel), int'(cfgRegIdx));
      if (autoconfDone) checkOutput(EV_DONE, 0, 0);
    end
  end

  // Engine model: answers each start with a done pulse two cycles later.
  initial begin
    cfgDone = 1'b0;
    forever begin
      @(negedge clk);
      if (cfgStart && !rst && !(dropEn && cfgAdcSel == 1'b1 && cfgRegIdx == 2'd1)) begin
        @(posedge clk);
        @(posedge clk);
        #1 cfgDone = 1'b1;
        @(posedge clk);
        #1 cfgDone = 1'b0;
      end
    end
  end

  task automatic pushStart(input int adc, input int regIdx);
    expQ.push_back('{kind: EV_START, adc: adc, regIdx: regIdx});
  endtask

  task automatic pushDone();
    expQ.push_back('{kind: EV_DONE, adc: 0, regIdx: 0});
  endtask

  task automatic expectSequence(input logic [1:0] mask);
    for (int a = 0; a < NUM_ADC; a++)
      if (mask[a])
        for (int r = 0; r < NUM_REGS; r++) pushStart(a, r);
    pushDone();
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input logic busy);
    rst        = 1'b1;
    adcMask    = mask;
    cfgBusyExt = busy;
    adcRst     = 1'b0;
    restart    = 1'b0;
    repeat (3) @(posedge clk);
    expQ.delete();
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic measureLatency(input string name, input int expected, input bit wantDone);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      seen = wantDone ? autoconfDone : cfgStart;
    end
    checkValue(name, seen ? n : -1, expected);
  endtask

  task automatic waitDone(input string name, input int maxCycles);
    bit found;
    found = 1'b0;
    for (int i = 0; i < maxCycles && !found; i++) begin
      @(negedge clk);
      found = autoconfDone;
    end
    checkValue(name, found, 1);
  endtask

  task automatic waitForStart(input string name, input int adc, input int regIdx);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = cfgStart && (int'(cfgAdcSel) == adc) && (int'(cfgRegIdx) == regIdx);
    end
    checkValue(name, found, 1);
  endtask

  task automatic finishTest(input string name);
    repeat (2) @(negedge clk);
    checkValue({name, " run low"}, run, 0);
    checkValue({name, " scoreboard drained"}, expQ.size(), 0);
  endtask

  initial begin
    int badStart;
    int badRun;

    $display("[TB] full mask, reset values and first-start latency");
    applyStimulus(2'b11, 1'b0);
    @(negedge clk);
    checkValue("reset cfg_start", cfgStart, 0);
    checkValue("reset cfg_adc_sel", cfgAdcSel, 0);
    checkValue("reset cfg_reg_idx", cfgRegIdx, 0);
    checkValue("reset autoconf_done", autoconfDone, 0);
    checkValue("reset autoconf_err", autoconfErr, 0);
    checkValue("reset err_adc", errAdc, 0);
    checkValue("reset err_reg", errReg, 0);
    checkValue("reset run", run, 1);
    expectSequence(2'b11);
    releaseReset();
    measureLatency("first start latency", 6, 1'b0);
    waitDone("full mask done", 200);
    finishTest("full mask");
    checkValue("no error after clean run", autoconfErr, 0);

    $display("[TB] mask 2'b10");
    applyStimulus(2'b10, 1'b0);
    expectSequence(2'b10);
    releaseReset();
    measureLatency("skip adc0 latency", 7, 1'b0);
    waitDone("mask 10 done", 200);
    finishTest("mask 10");

    $display("[TB] mask 2'b00");
    applyStimulus(2'b00, 1'b0);
    expectSequence(2'b00);
    releaseReset();
    measureLatency("empty mask done latency", 7, 1'b1);
    finishTest("mask 00");

    $display("[TB] external busy holds off the sequence");
    applyStimulus(2'b11, 1'b1);
    expectSequence(2'b11);
    releaseReset();
    badStart = 0;
    badRun = 0;
    repeat (50) begin
      @(negedge clk);
      if (cfgStart) badStart++;
      if (!run) badRun++;
    end
    checkValue("busy blocks start", badStart, 0);
    checkValue("busy keeps run high", badRun, 0);
    @(posedge clk);
    #1 cfgBusyExt = 1'b0;
    measureLatency("busy release latency", 6, 1'b0);
    waitDone("busy done", 200);
    finishTest("busy");

    $display("[TB] adc_rst abort during second write");
    applyStimulus(2'b11, 1'b0);
    pushStart(0, 0);
    pushStart(0, 1);
    expectSequence(2'b11);
    releaseReset();
    waitForStart("abort reaches (0,1)", 0, 1);
    @(posedge clk);
    #1 adcRst = 1'b1;
    @(posedge clk);
    #1 adcRst = 1'b0;
    measureLatency("abort restart latency", 6, 1'b0);
    waitDone("abort done", 200);
    finishTest("abort");

    $display("[TB] restart mid-sequence reruns after finish");
    applyStimulus(2'b11, 1'b0);
    expectSequence(2'b11);
    expectSequence(2'b11);
    releaseReset();
    waitForStart("restart reaches (0,2)", 0, 2);
    @(posedge clk);
    #1 restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    waitDone("restart first done", 200);
    waitDone("restart second done", 200);
    finishTest("restart");

`ifdef ADC_AUTOCFG_TIMEOUT_EN
    $display("[TB] timeout and retry on (1,1)");
    applyStimulus(2'b11, 1'b0);
    dropEn = 1'b1;
    pushStart(0, 0);
    pushStart(0, 1);
    pushStart(0, 2);
    pushStart(1, 0);
    pushStart(1, 1);
    pushStart(1, 1);
    pushStart(1, 1);
    pushDone();
    releaseReset();
    waitDone("timeout done", 400);
    finishTest("timeout");
    checkValue("timeout autoconf_err", autoconfErr, 1);
    checkValue("timeout err_adc", errAdc, 1);
    checkValue("timeout err_reg", errReg, 1);
    dropEn = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
